// File: rtl/al_mul_acc_if.sv
// Operand/result bundle for the shift-and-add multiply-accumulate unit.
interface al_mul_acc_if #(
  parameter int unsigned N = 16
);
  logic           en;
  logic           start;
  logic [N-1:0]   Multiplicand;
  logic [N-1:0]   Multiplier;
  logic [N-1:0]   Addend;
  logic [2*N-1:0] Product;
  logic           exceeds_n;
  logic           busy;
  logic           done;

  modport master (
    output en, start, Multiplicand, Multiplier, Addend,
    input  Product, exceeds_n, busy, done
  );

  modport slave (
    input  en, start, Multiplicand, Multiplier, Addend,
    output Product, exceeds_n, busy, done
  );
endinterface

// File: rtl/al_mul_acc.sv
// Sequential unsigned multiply-accumulate: Product = Multiplicand*Multiplier + Addend,
// one multiplier bit per enabled cycle, fixed N-cycle latency.
module al_mul_acc #(
  parameter int unsigned N = 16
) (
  input  logic          mclk,
  input  logic          rst,
  al_mul_acc_if.slave   bus
);
  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [W-1:0]  sum_c;

  // Partial sum for the current multiplier bit; a_sh already carries the bit-index shift.
  always_comb begin
    sum_c = acc + (b_sh[0] ? a_sh : '0);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      bus.Product   <= '0;
      bus.exceeds_n <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              a_sh     <= W'(bus.Multiplicand);
              b_sh     <= bus.Multiplier;
              acc      <= W'(bus.Addend);
              cnt      <= CW'(N);
              bus.busy <= 1'b1;
              state    <= RUN;
            end
          end
          RUN: begin
            acc  <= sum_c;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
            // Last multiplier bit: publish the result and drop back to idle.
            if (cnt == CW'(1)) begin
              bus.Product   <= sum_c;
              bus.exceeds_n <= |sum_c[W-1:N];
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_al_mul_acc.sv
// Directed self-checking bench for al_mul_acc (N=16).
module tb_al_mul_acc;
  localparam int unsigned N = 16;

  logic mclk;
  logic rst;
  int   n_cmp;
  int   n_err;

  al_mul_acc_if #(.N(N)) bus ();

  al_mul_acc #(.N(N)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until done is seen; cyc = number of steps taken, -1 if the bound expires.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic set_ops(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    bus.Addend       = c;
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [2*N-1:0] exp_p, input logic exp_x);
    int cyc;
    set_ops(a, b, c);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(16));
    chk({tag, "_prod"}, 64'(bus.Product), 64'(exp_p));
    chk({tag, "_exc"}, 64'(bus.exceeds_n), 64'(exp_x));
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
    step();
    chk({tag, "_done_clr"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int cyc;
    int tot;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.start = 1'b0;
    set_ops('0, '0, '0);
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_prod", 64'(bus.Product), 64'(0));
    chk("rst_exc", 64'(bus.exceeds_n), 64'(0));

    // Start with en low in idle is ignored
    bus.en = 1'b0;
    bus.start = 1'b1;
    set_ops(16'd1, 16'd1, 16'd1);
    step();
    chk("stall_start_busy", 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
    bus.en = 1'b1;
    step();
    chk("stall_start_busy2", 64'(bus.busy), 64'(0));

    // Basic 7*13+5, with per-cycle busy/done/product-hold checks
    set_ops(16'd7, 16'd13, 16'd5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("basic_busy", 64'(bus.busy), 64'(1));
      chk("basic_done", 64'(bus.done), 64'(0));
      chk("basic_hold", 64'(bus.Product), 64'(0));
      step();
    end
    chk("basic_busy15", 64'(bus.busy), 64'(1));
    step();
    chk("basic_done16", 64'(bus.done), 64'(1));
    chk("basic_prod", 64'(bus.Product), 64'(96));
    chk("basic_exc", 64'(bus.exceeds_n), 64'(0));
    chk("basic_busy_end", 64'(bus.busy), 64'(0));
    step();
    chk("basic_done_clr", 64'(bus.done), 64'(0));
    chk("basic_prod_hold", 64'(bus.Product), 64'(96));

    run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b1);
    run_op("bzero", 16'h1234, 16'h0000, 16'hBEEF, 32'h0000_BEEF, 1'b0);
    run_op("pow", 16'h0100, 16'h0100, 16'h0000, 32'h0001_0000, 1'b1);

    // Starts while busy are ignored; start in the done cycle is accepted
    set_ops(16'd3, 16'd5, 16'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3 || k == 10) begin
        bus.start = 1'b1;
        set_ops(16'd100, 16'd100, 16'd9);
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk("ign_done", 64'(bus.done), 64'(1));
    chk("ign_prod", 64'(bus.Product), 64'(16));
    set_ops(16'd2, 16'd3, 16'd4);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'(1));
    chk("b2b_done_low", 64'(bus.done), 64'(0));
    wait_done(cyc);
    chk("b2b_gap", 64'(cyc + 1), 64'(17));
    chk("b2b_prod", 64'(bus.Product), 64'(10));

    // Three-cycle stall mid-run
    step();
    set_ops(16'd9, 16'd11, 16'd2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bus.en = 1'b0;
    set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_done", 64'(bus.done), 64'(0));
      chk("stall_busy", 64'(bus.busy), 64'(1));
    end
    bus.en = 1'b1;
    wait_done(cyc);
    tot = 4 + 3 + cyc;
    if (cyc < 0) tot = -1;
    chk("stall_lat", 64'(tot), 64'(19));
    chk("stall_prod", 64'(bus.Product), 64'(101));
    chk("stall_exc", 64'(bus.exceeds_n), 64'(0));

    // Reset mid-run aborts without a done pulse
    step();
    set_ops(16'd5, 16'd6, 16'd7);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_prod", 64'(bus.Product), 64'(0));
    chk("abort_exc", 64'(bus.exceeds_n), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    for (int k = 0; k < 20; k++) begin
      step();
      chk("abort_no_done", 64'(bus.done), 64'(0));
    end
    run_op("post_rst", 16'h00FF, 16'h0101, 16'h0003, 32'h0001_0002, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/al_mul_acc.md
AL_MUL_ACC -- requirements
Module: al_mul_acc

Interface
REQ-001 Parameter: N, default 16, operand width in bits; legal range N >= 2.
REQ-002 mclk  input  1  master clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  enable; low = stall, all operation state held.
REQ-005 start  input  1  request a new operation; sampled only when idle and en=1.
REQ-006 Multiplicand  input  N  unsigned operand A (divisor role).
REQ-007 Multiplier  input  N  unsigned operand B (quotient role).
REQ-008 Addend  input  N  unsigned operand C (remainder role).
REQ-009 Product  output  2N  registered result A*B + C.
REQ-010 exceeds_n  output  1  registered; 1 when the completed result is >= 2^N.
REQ-011 busy  output  1  registered; 1 while an operation is in progress.
REQ-012 done  output  1  registered single-cycle completion pulse.

Function
REQ-013 The block SHALL compute Product = Multiplicand*Multiplier + Addend, all unsigned; the maximum value 2^2N - 2^N fits in 2N bits, so no overflow is possible.
REQ-014 The block SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-015 In IDLE with en=1 and start=1 at edge E0, the block SHALL latch all three operands, preload the 2N-bit accumulator with zero-extended Addend, load the bit counter with N, and enter RUN.
REQ-016 In RUN, each enabled edge SHALL process exactly one Multiplier bit, LSB first: if the bit is 1, add the Multiplicand shifted left by the bit index to the accumulator; then decrement the counter.
REQ-017 Latency SHALL be fixed at N enabled RUN edges regardless of operand values; there is no early termination on zero operands.
REQ-018 On the enabled edge that processes bit N-1 (edge EN when no stalls occur), the block SHALL register the final sum into Product, register exceeds_n = (sum[2N-1:N] != 0), set done=1, clear busy, and return to IDLE.
REQ-019 done SHALL be high for exactly one cycle, on the cycle after the completing edge, and SHALL be 0 on every other cycle.
REQ-020 Product and exceeds_n SHALL hold their last completed values until the next completion or reset; they SHALL NOT change during RUN.
REQ-021 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-022 start asserted in the cycle where done=1 SHALL be accepted (the state is IDLE), so back-to-back operations complete every N+1 cycles.
REQ-023 Operand inputs SHALL be sampled only at the accepting edge; changes during RUN SHALL NOT affect the result.
REQ-024 On an edge with en=0, the block SHALL hold the state, counter, accumulator, latched operands, busy, Product and exceeds_n, SHALL force done to 0, and SHALL ignore start.
REQ-025 A completion cannot fall on a stalled edge; done SHALL assert only after the Nth enabled RUN edge, so each stalled cycle delays done by one cycle.

Reset
REQ-026 On rst=1 at a rising edge, the block SHALL go to IDLE and set Product=0, exceeds_n=0, busy=0, done=0, counter=0 and accumulator=0.
REQ-027 rst SHALL take priority over en and start.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; start and en are ignored on that edge.
REQ-029 The first start accepted after reset release SHALL behave exactly as in REQ-015.

Verification
REQ-030 N=16; A=7, B=13, C=5, start for 1 cycle -> busy=1 for 16 cycles, done pulses 16 cycles after the start edge, Product=96, exceeds_n=0.
REQ-031 N=16; A=B=C=0xFFFF -> Product=0xFFFF0000, exceeds_n=1.
REQ-032 N=16; B=0, A=0x1234, C=0xBEEF -> Product=0xBEEF after the full 16-cycle latency, exceeds_n=0; then A=0x0100, B=0x0100, C=0 -> Product=0x10000, exceeds_n=1.
REQ-033 Start pulses at cycles 3 and 10 after the first start, with changed operands -> both ignored, result matches the first operands; a start asserted during the done cycle -> accepted, and the second done arrives 17 cycles after the first.
REQ-034 en=0 for 3 cycles mid-RUN -> done delayed by exactly 3 cycles and equal to 0 throughout the stall; result unchanged.
REQ-035 rst asserted for 1 cycle at RUN cycle 8 -> busy=0, Product=0, no done pulse; a subsequent start computes correctly.
